veda_mem_ops: RTL and testbench
===============================

VEDA_MEM_OPS -- requirements
Module: veda_mem_ops

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the word width in bits.
REQ-002 Parameter ADDR_W, default 6, SHALL set the address width; depth SHALL be 2**ADDR_W words.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 start  input  1  SHALL be the operation request, sampled on rising edges.
REQ-006 op  input  2  SHALL be the opcode: 00 WRITE, 01 READ, 10 ADD, 11 SWAP.
REQ-007 address_a  input  ADDR_W  SHALL be the destination / first-operand address.
REQ-008 address_b  input  ADDR_W  SHALL be the source / second-operand address.
REQ-009 dataIn  input  DATA_W  SHALL be the write data for WRITE.
REQ-010 dataOut  output  DATA_W  SHALL be the registered result of the last completed operation.
REQ-011 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-012 done  output  1  SHALL be a one-cycle registered pulse marking completion.

Function
REQ-013 FSM states SHALL be IDLE, EXEC and SWP2.
REQ-014 Accept edge: state IDLE and start=1 SHALL latch op, address_a, address_b and dataIn, read mem[address_a] into opA and mem[address_b] into opB, and move to EXEC.
REQ-015 start while busy=1 SHALL be ignored, with no queuing.
REQ-016 EXEC edge, WRITE: mem[a]<=dataIn_q; dataOut<=dataIn_q; done=1; go to IDLE.
REQ-017 EXEC edge, READ: dataOut<=opB; memory unchanged; done=1; go to IDLE.
REQ-018 EXEC edge, ADD: mem[a] and dataOut <= (opA+opB) truncated to DATA_W bits, wrapping; done=1; go to IDLE.
REQ-019 EXEC edge, SWAP: mem[a]<=opB; go to SWP2. The SWP2 edge: mem[b]<=opA; dataOut<=opA; done=1; go to IDLE.
REQ-020 Latency from accept edge to done high SHALL be 1 edge for WRITE/READ/ADD and 2 edges for SWAP; back-to-back issue SHALL be possible in the done cycle.
REQ-021 a==b SHALL be legal: ADD doubles the word; SWAP leaves memory unchanged.
REQ-022 Operands SHALL be the values captured at the accept edge, immune to input changes while busy.

Reset
REQ-023 rst=0 SHALL force, asynchronously: state IDLE, busy=0, done=0, dataOut=0, all memory words=0, internal latches=0.
REQ-024 Reset mid-operation SHALL abort it; a SWAP interrupted after EXEC SHALL leave no effect after reset.
REQ-025 The first accept SHALL occur no earlier than the first rising edge after rst rises.

Configuration
REQ-026 Macro VEDA_MEM_SAT_EN defined: ADD SHALL saturate to all-ones on carry-out.
REQ-027 Macro VEDA_MEM_SAT_EN undefined: ADD SHALL wrap modulo 2**DATA_W; interface identical in both builds.

Structure
REQ-028 Package veda_mem_pkg SHALL hold the opcode encodings, the FSM state encodings and the defaults for DATA_W/ADDR_W.
REQ-029 Sub-module veda_mem_alu (combinational ADD, sat/wrap per macro) SHALL be instantiated once; the storage array and FSM stay in veda_mem_ops.

Verification
REQ-030 Reset, then WRITE a=5 din=27, WRITE a=8 din=26, READ b=5 -> dataOut=27, done one cycle, busy low at done.
REQ-031 After REQ-030: ADD a=5 b=8 -> dataOut=53, READ b=5 -> 53; ADD a=23 (=0) b=5 -> 53.
REQ-032 Set mem[8]=200, mem[5]=100, ADD a=8 b=5 -> 44 wrap, or 255 with VEDA_MEM_SAT_EN.
REQ-033 SWAP a=5 b=8 with 27/26 -> busy 2 cycles, dataOut=27, READ 5 -> 26, READ 8 -> 27; start pulses during busy have no effect.
REQ-034 SWAP issued, rst low in SWP2 -> busy=0, dataOut=0, READ 5 and READ 8 -> 0.
REQ-035 Parameter run DATA_W=16, ADDR_W=4: WRITE a=15 din=16'hFFFF, ADD a=15 b=15 -> 16'hFFFE (16'hFFFF saturated).

Source files
------------

// File: rtl/veda_mem_pkg.sv
// veda_mem_pkg: shared opcode and FSM state encodings plus default widths
// for the veda_mem_ops memory-operation engine.
package veda_mem_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_ADD   = 2'b10,
    OP_SWAP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_SWP2 = 2'b10
  } state_e;

endpackage

// File: rtl/veda_mem_ops_if.sv
// veda_mem_ops_if: request/response bundle of the memory-operation engine.
// The master issues operations; the slave (veda_mem_ops) executes them.
interface veda_mem_ops_if #(
  parameter int DATA_W = veda_mem_pkg::DATA_W_DEF,
  parameter int ADDR_W = veda_mem_pkg::ADDR_W_DEF
);
  logic              start;
  logic [1:0]        op;
  logic [ADDR_W-1:0] address_a;
  logic [ADDR_W-1:0] address_b;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataOut;
  logic              busy;
  logic              done;

  modport master (
    output start, op, address_a, address_b, dataIn,
    input  dataOut, busy, done
  );

  modport slave (
    input  start, op, address_a, address_b, dataIn,
    output dataOut, busy, done
  );
endinterface

// File: rtl/veda_mem_alu.sv
// veda_mem_alu: combinational adder for the ADD operation.
// Build option VEDA_MEM_SAT_EN: when defined the sum saturates to all-ones on
// carry-out; otherwise it wraps modulo 2**DATA_W.
module veda_mem_alu #(
  parameter int DATA_W = veda_mem_pkg::DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);
  logic [DATA_W:0] full_s;

  // widen by one bit so the carry-out is visible
  always_comb begin
    full_s = {1'b0, a} + {1'b0, b};
`ifdef VEDA_MEM_SAT_EN
    if (full_s[DATA_W]) begin
      sum = {DATA_W{1'b1}};
    end else begin
      sum = full_s[DATA_W-1:0];
    end
`else
    sum = full_s[DATA_W-1:0];
`endif
  end
endmodule

// File: rtl/veda_mem_ops.sv
// veda_mem_ops: small register-file engine executing WRITE / READ / ADD / SWAP
// on a 2**ADDR_W x DATA_W array. Operands are snapshotted on the accept edge,
// so input changes while busy never disturb a running operation.
// Build option VEDA_MEM_SAT_EN selects a saturating ADD (see veda_mem_alu).
module veda_mem_ops
  import veda_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  veda_mem_ops_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  state_e            state_r;
  state_e            state_s;
  op_e               op_r;
  logic [ADDR_W-1:0] addr_a_r;
  logic [ADDR_W-1:0] addr_b_r;
  logic [DATA_W-1:0] din_r;
  logic [DATA_W-1:0] opa_r;
  logic [DATA_W-1:0] opb_r;
  logic [DATA_W-1:0] dout_r;
  logic [DATA_W-1:0] dout_s;
  logic              done_r;
  logic              done_s;
  logic              accept_s;
  logic              we_s;
  logic [ADDR_W-1:0] waddr_s;
  logic [DATA_W-1:0] wdata_s;
  logic [DATA_W-1:0] sum_s;
  logic [DATA_W-1:0] mem_r [DEPTH];

  veda_mem_alu #(.DATA_W(DATA_W)) u_alu (
    .a   (opa_r),
    .b   (opb_r),
    .sum (sum_s)
  );

  // next state, single memory write port and result selection
  always_comb begin
    state_s  = state_r;
    dout_s   = dout_r;
    done_s   = 1'b0;
    accept_s = 1'b0;
    we_s     = 1'b0;
    waddr_s  = addr_a_r;
    wdata_s  = din_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          accept_s = 1'b1;
          state_s  = ST_EXEC;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_EXEC: begin
        case (op_r)
          OP_WRITE: begin
            we_s    = 1'b1;
            wdata_s = din_r;
            dout_s  = din_r;
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end
          OP_READ: begin
            dout_s  = opb_r;
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end
          OP_ADD: begin
            we_s    = 1'b1;
            wdata_s = sum_s;
            dout_s  = sum_s;
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end
          OP_SWAP: begin
            // first half: destination takes the source word
            we_s    = 1'b1;
            wdata_s = opb_r;
            state_s = ST_SWP2;
          end
          default: begin
            state_s = ST_IDLE;
          end
        endcase
      end
      ST_SWP2: begin
        // second half: source takes the snapshotted destination word
        we_s    = 1'b1;
        waddr_s = addr_b_r;
        wdata_s = opa_r;
        dout_s  = opa_r;
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      dout_r  <= {DATA_W{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      dout_r  <= dout_s;
      done_r  <= done_s;
    end
  end

  // operand and request snapshot taken on the accept edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r     <= OP_WRITE;
      addr_a_r <= {ADDR_W{1'b0}};
      addr_b_r <= {ADDR_W{1'b0}};
      din_r    <= {DATA_W{1'b0}};
      opa_r    <= {DATA_W{1'b0}};
      opb_r    <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      op_r     <= op_e'(bus.op);
      addr_a_r <= bus.address_a;
      addr_b_r <= bus.address_b;
      din_r    <= bus.dataIn;
      opa_r    <= mem_r[bus.address_a];
      opb_r    <= mem_r[bus.address_b];
    end
  end

  // storage array, cleared by reset so an aborted SWAP leaves no trace
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

  assign bus.busy    = (state_r != ST_IDLE);
  assign bus.done    = done_r;
  assign bus.dataOut = dout_r;

endmodule

// File: tb/tb_veda_mem_ops.sv
// tb_veda_mem_ops: directed bench for veda_mem_ops. A word-level model of the
// memory predicts every result; a per-cycle compare process checks busy, done
// and dataOut against an operation timeline, and literal checks pin the model.
// A second 16/4 instance exercises the wide-word ADD corner.
module tb_veda_mem_ops;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  veda_mem_ops_if #(.DATA_W(8),  .ADDR_W(6)) ifc ();
  veda_mem_ops_if #(.DATA_W(16), .ADDR_W(4)) ifw ();

  veda_mem_ops #(.DATA_W(8),  .ADDR_W(6)) dut  (.clk(clk), .rst(rst), .bus(ifc));
  veda_mem_ops #(.DATA_W(16), .ADDR_W(4)) dutw (.clk(clk), .rst(rst), .bus(ifw));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // model state: memory image, last result and current operation timeline
  logic [7:0] mem_m [64];
  logic [7:0] exp_dout = 8'd0;
  int         acc_cyc  = -100;
  int         lat      = 1;
  bit         exp_b;
  bit         exp_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_add(input int x, input int y);
    int s;
    s = x + y;
`ifdef VEDA_MEM_SAT_EN
    if (s > 255) s = 255;
`endif
    return 8'(s % 256);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // every cycle: busy spans the latency after accept, done the cycle after
  always @(negedge clk) begin
    exp_b = (cyc >= acc_cyc) && (cyc < acc_cyc + lat);
    exp_d = (cyc == acc_cyc + lat);
    check("cyc_busy", {31'd0, ifc.busy}, {31'd0, exp_b});
    check("cyc_done", {31'd0, ifc.done}, {31'd0, exp_d});
    check("cyc_dout", {24'd0, ifc.dataOut}, {24'd0, exp_dout});
  end

  // issue one operation; optionally hold start high with junk while busy
  task automatic do_op(input logic [1:0] o, input int a, input int b, input int din,
                       input bit noise);
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] res;
    int lt;
    va = mem_m[a];
    vb = mem_m[b];
    lt = (o == 2'b11) ? 2 : 1;
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.op = o;
    ifc.address_a = 6'(a);
    ifc.address_b = 6'(b);
    ifc.dataIn = 8'(din);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    lat = lt;
    ifc.address_a = ~6'(a);
    ifc.address_b = ~6'(b);
    ifc.dataIn = ~8'(din);
    ifc.start = noise;
    if (noise) ifc.op = 2'b00;
    repeat (lt) @(posedge clk);
    #1;
    ifc.start = 1'b0;
    case (o)
      2'b00: begin mem_m[a] = 8'(din); res = 8'(din); end
      2'b01: res = vb;
      2'b10: begin res = model_add(int'(va), int'(vb)); mem_m[a] = res; end
      default: begin mem_m[a] = vb; mem_m[b] = va; res = va; end
    endcase
    exp_dout = res;
  endtask

  task automatic wide_op(input logic [1:0] o, input int a, input int b, input logic [15:0] din,
                         input string name, input logic [15:0] exp);
    @(negedge clk);
    ifw.start = 1'b1;
    ifw.op = o;
    ifw.address_a = 4'(a);
    ifw.address_b = 4'(b);
    ifw.dataIn = din;
    @(posedge clk);
    #1;
    ifw.start = 1'b0;
    check({name, "_busy"}, {31'd0, ifw.busy}, 32'd1);
    @(posedge clk);
    #1;
    check({name, "_done"}, {31'd0, ifw.done}, 32'd1);
    check(name, {16'd0, ifw.dataOut}, {16'd0, exp});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_m[i] = 8'd0;
    ifc.start = 1'b0; ifc.op = 2'b00; ifc.address_a = 6'd0; ifc.address_b = 6'd0; ifc.dataIn = 8'd0;
    ifw.start = 1'b0; ifw.op = 2'b00; ifw.address_a = 4'd0; ifw.address_b = 4'd0; ifw.dataIn = 16'd0;

    // reset state; start is held high during reset and must not be taken early
    @(negedge clk);
    ifc.start = 1'b1;
    #1;
    check("rst_busy", {31'd0, ifc.busy}, 32'd0);
    check("rst_done", {31'd0, ifc.done}, 32'd0);
    check("rst_dout", {24'd0, ifc.dataOut}, 32'd0);
    @(negedge clk);
    ifc.start = 1'b0;
    rst = 1'b1;

    // basic write / read
    do_op(2'b00, 5, 0, 27, 1'b0);
    do_op(2'b00, 8, 0, 26, 1'b0);
    do_op(2'b01, 0, 5, 0, 1'b0);
    check("read5_lit", {24'd0, ifc.dataOut}, 32'd27);
    check("read5_done", {31'd0, ifc.done}, 32'd1);
    check("read5_busy", {31'd0, ifc.busy}, 32'd0);

    // add chain, including an operand from an unwritten word
    do_op(2'b10, 5, 8, 0, 1'b0);
    check("add58_lit", {24'd0, ifc.dataOut}, 32'd53);
    do_op(2'b01, 0, 5, 0, 1'b0);
    check("read5b_lit", {24'd0, ifc.dataOut}, 32'd53);
    do_op(2'b10, 23, 5, 0, 1'b0);
    check("add23_lit", {24'd0, ifc.dataOut}, 32'd53);

    // overflow: wrap or saturate
    do_op(2'b00, 8, 0, 200, 1'b0);
    do_op(2'b00, 5, 0, 100, 1'b0);
    do_op(2'b10, 8, 5, 0, 1'b0);
`ifdef VEDA_MEM_SAT_EN
    check("add_ovf_lit", {24'd0, ifc.dataOut}, 32'd255);
`else
    check("add_ovf_lit", {24'd0, ifc.dataOut}, 32'd44);
`endif

    // swap with junk start pulses during busy
    do_op(2'b00, 5, 0, 27, 1'b0);
    do_op(2'b00, 8, 0, 26, 1'b0);
    do_op(2'b11, 5, 8, 0, 1'b1);
    check("swap_lit", {24'd0, ifc.dataOut}, 32'd27);
    do_op(2'b01, 0, 5, 0, 1'b0);
    check("swap_r5_lit", {24'd0, ifc.dataOut}, 32'd26);
    do_op(2'b01, 0, 8, 0, 1'b0);
    check("swap_r8_lit", {24'd0, ifc.dataOut}, 32'd27);

    // a == b corners
    do_op(2'b00, 3, 0, 7, 1'b0);
    do_op(2'b10, 3, 3, 0, 1'b0);
    check("add_self_lit", {24'd0, ifc.dataOut}, 32'd14);
    do_op(2'b11, 3, 3, 0, 1'b0);
    check("swap_self_lit", {24'd0, ifc.dataOut}, 32'd14);
    do_op(2'b01, 0, 3, 0, 1'b0);
    check("swap_self_mem", {24'd0, ifc.dataOut}, 32'd14);

    // reset during the second half of a swap
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = 2'b11; ifc.address_a = 6'd5; ifc.address_b = 6'd8;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    lat = 2;
    ifc.start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    acc_cyc = -100;
    exp_dout = 8'd0;
    for (int i = 0; i < 64; i++) mem_m[i] = 8'd0;
    #1;
    check("abort_busy", {31'd0, ifc.busy}, 32'd0);
    check("abort_dout", {24'd0, ifc.dataOut}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    do_op(2'b01, 0, 5, 0, 1'b0);
    check("abort_r5", {24'd0, ifc.dataOut}, 32'd0);
    do_op(2'b01, 0, 8, 0, 1'b0);
    check("abort_r8", {24'd0, ifc.dataOut}, 32'd0);

    // wide instance
    wide_op(2'b00, 15, 0, 16'hFFFF, "w_write", 16'hFFFF);
`ifdef VEDA_MEM_SAT_EN
    wide_op(2'b10, 15, 15, 16'h0000, "w_add", 16'hFFFF);
`else
    wide_op(2'b10, 15, 15, 16'h0000, "w_add", 16'hFFFE);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
